// File: rtl/xlr8_clken_gen.sv
// Microsecond base-tick prescaler feeding NUM_CH programmable enable-pulse channels.
// CTRL (channel run bits), STAT (W1C pulse flags) and DIV[n] live on the data-memory bus.
module xlr8_clken_gen #(
   parameter int         NUM_CH    = 4,
   parameter int         CLK_DIV1M = 16,
   parameter logic [7:0] BASE_ADDR = 8'hE0,
   parameter logic [7:0] DIV_RST   = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        ramadr,
   input  logic              dm_sel,
   input  logic              ramre,
   input  logic              ramwe,
   input  logic [7:0]        dbus_in,
   output logic [7:0]        dbus_out,
   output logic              io_out_en,
   output logic              tick_1us,
   output logic [NUM_CH-1:0] en_out
);

   localparam logic [7:0] PRESC_MAX = 8'(CLK_DIV1M - 1);
   localparam logic [7:0] CTRL_ADDR = BASE_ADDR;
   localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;

   function automatic logic [7:0] div_addr(input int ch);
      return BASE_ADDR + 8'd2 + 8'(ch);
   endfunction

   logic [7:0]        presc_r;
   logic              tick_r;
   logic [NUM_CH-1:0] ctrl_r;
   logic [NUM_CH-1:0] stat_r;
   logic [NUM_CH-1:0] en_r;
   logic [7:0]        div_r [NUM_CH];
   logic [7:0]        cnt_r [NUM_CH];

   logic              ctrl_sel_s;
   logic              stat_sel_s;
   logic [NUM_CH-1:0] div_sel_s;
   logic              any_sel_s;
   logic              ctrl_we_s;
   logic              stat_we_s;
   logic [NUM_CH-1:0] div_we_s;
   logic [NUM_CH-1:0] stat_clr_s;
   logic [7:0]        rdata_s;

   // Address decode, write strobes and OR-combined read mux.
   always_comb begin
      ctrl_sel_s = dm_sel && (ramadr == CTRL_ADDR);
      stat_sel_s = dm_sel && (ramadr == STAT_ADDR);
      div_sel_s  = {NUM_CH{1'b0}};
      for (int n = 0; n < NUM_CH; n++) begin
         div_sel_s[n] = dm_sel && (ramadr == div_addr(n));
      end
      any_sel_s  = ctrl_sel_s || stat_sel_s || (|div_sel_s);
      ctrl_we_s  = ctrl_sel_s && ramwe;
      stat_we_s  = stat_sel_s && ramwe;
      div_we_s   = div_sel_s & {NUM_CH{ramwe}};
      stat_clr_s = stat_we_s ? dbus_in[NUM_CH-1:0] : {NUM_CH{1'b0}};
      rdata_s    = ({8{ctrl_sel_s}} & 8'(ctrl_r)) | ({8{stat_sel_s}} & 8'(stat_r));
      for (int n = 0; n < NUM_CH; n++) begin
         rdata_s = rdata_s | ({8{div_sel_s[n]}} & div_r[n]);
      end
   end

   assign dbus_out  = rdata_s;
   assign io_out_en = any_sel_s && ramre;
   assign tick_1us  = tick_r;
   assign en_out    = en_r;

   // Base prescaler: tick_r is high for the cycle after the counter reads 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= PRESC_MAX;
         tick_r  <= 1'b0;
      end else if (presc_r == 8'd0) begin
         presc_r <= PRESC_MAX;
         tick_r  <= 1'b1;
      end else begin
         presc_r <= presc_r - 8'd1;
         tick_r  <= 1'b0;
      end
   end

   // Software-visible registers; a pulse setting STAT beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r <= {NUM_CH{1'b0}};
         stat_r <= {NUM_CH{1'b0}};
         for (int n = 0; n < NUM_CH; n++) begin
            div_r[n] <= DIV_RST;
         end
      end else begin
         if (ctrl_we_s) begin
            ctrl_r <= dbus_in[NUM_CH-1:0];
         end
         stat_r <= (stat_r & ~stat_clr_s) | en_r;
         for (int n = 0; n < NUM_CH; n++) begin
            if (div_we_s[n]) begin
               div_r[n] <= dbus_in;
            end
         end
      end
   end

   // Per-channel down-counters; uses registered CTRL so a same-cycle disable still honours the tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_r <= {NUM_CH{1'b0}};
         for (int n = 0; n < NUM_CH; n++) begin
            cnt_r[n] <= 8'h00;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (!ctrl_r[n]) begin
               cnt_r[n] <= 8'h00;
               en_r[n]  <= 1'b0;
            end else if (tick_r) begin
               if (cnt_r[n] == 8'h00) begin
                  cnt_r[n] <= div_r[n];
                  en_r[n]  <= 1'b1;
               end else begin
                  cnt_r[n] <= cnt_r[n] - 8'h01;
                  en_r[n]  <= 1'b0;
               end
            end else begin
               en_r[n] <= 1'b0;
            end
         end
      end
   end

endmodule
